// File: rtl/rv32_pipe_pkg.sv
// Shared types and constants for the RV32 pipeline-stage queues.
// Stage payloads are opaque to the queue; the stages pack and unpack them.
package rv32_pipe_pkg;

  // Canonical RV32 NOP: ADDI x0, x0, 0.
  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  // ID/EX stage payload.
  typedef struct packed {
    logic [31:0] code;
    logic [31:0] pc;
    logic [31:0] pc_ret;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [5:0]  alu;
    logic [2:0]  rf;
    logic [3:0]  bshift;
    logic        pc_hlt;
    logic [1:0]  data_ctrl;
    logic        sel_rs1;
    logic        sel_rs2;
    logic        sel_rd1;
  } id_ex_pl_t;

  // EX/MEM stage payload.
  typedef struct packed {
    logic [31:0] code;
    logic [31:0] pc;
    logic [31:0] alu_res;
    logic [31:0] rs2_data;
    logic [1:0]  data_ctrl;
    logic [2:0]  rf;
    logic        sel_rd1;
  } ex_mem_pl_t;

  // Bubble value for an ID/EX queue: an ALU no-op that does not halt-advance the PC.
  localparam id_ex_pl_t ID_EX_NOP = '{
    code:      32'h0,
    pc:        32'h0,
    pc_ret:    32'h0,
    rs1_data:  32'h0,
    rs2_data:  32'h0,
    alu:       6'd7,
    rf:        3'd0,
    bshift:    4'd0,
    pc_hlt:    1'b1,
    data_ctrl: 2'b01,
    sel_rs1:   1'b0,
    sel_rs2:   1'b0,
    sel_rd1:   1'b0
  };

  // Pointer width for a circular buffer of the given depth (at least one bit).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/rv32_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Used for bubble counting here and by the performance monitor.
module rv32_sat_counter
  import rv32_pipe_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, else increment unless already all-ones.
  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      // NOTE: non-blocking so the flop samples the pre-edge value of cnt_d.
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/rv32_pipe_skid_queue.sv
// Pipeline-stage queue: DEPTH-entry circular buffer with valid/ready on both
// sides, flush (empty), hold (bubble out, block in, keep contents) and a
// saturating bubble counter. DEPTH=1 behaves as a pass-through register whose
// in_ready follows out_ready; DEPTH>=2 drives in_ready from registers only.
module rv32_pipe_skid_queue
  import rv32_pipe_pkg::*;
#(
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       DEPTH   = 2,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter int unsigned       CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       hold,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           bubble_cnt,
  input  logic                       bubble_clr
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [OCC_W-1:0] occ_t;

  localparam ptr_t LAST_PTR = ptr_t'(DEPTH - 1);
  localparam occ_t FULL_CNT = occ_t'(DEPTH);

  logic [DATA_W-1:0] storage_q [DEPTH];
  ptr_t              rd_ptr_q, rd_ptr_d;
  ptr_t              wr_ptr_q, wr_ptr_d;
  occ_t              count_q, count_d;
  logic              not_empty;
  logic              push;
  logic              pop;
  logic              bubble_inc;

  // Advance a pointer, wrapping at DEPTH (works for non-power-of-two depths).
  function automatic ptr_t ptr_next(input ptr_t p);
    return (p == LAST_PTR) ? '0 : p + ptr_t'(1);
  endfunction

  assign not_empty = (count_q != '0);
  assign out_valid = ~hold & not_empty;
  assign out_data  = out_valid ? storage_q[rd_ptr_q] : NOP_VAL;
  assign count     = count_q;

  generate
    if (DEPTH == 1) begin : g_pass
      // Single entry can be replaced in the same cycle it drains.
      assign in_ready = ~hold & (~not_empty | out_ready);
    end else begin : g_skid
      // Registered ready: no combinational path from out_ready.
      assign in_ready = ~hold & (count_q < FULL_CNT);
    end
  endgenerate

  // Flush suppresses both transfers; the head is not consumed by a flush.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Next pointers and occupancy from this cycle's transfers.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_next(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_next(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + occ_t'(1);
        2'b01:   count_d = count_q - occ_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers; reset to an empty queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage written at the tail on every accepted push.
  // NOTE: storage is deliberately not reset; out_data is muxed to NOP_VAL
  // whenever no entry is presented, so unwritten slots never reach the output.
  always_ff @(posedge clk) begin
    if (push) storage_q[wr_ptr_q] <= in_data;
  end

  // A bubble is a cycle where downstream could take data but none is offered;
  // flush cycles also count as bubbles.
  assign bubble_inc = flush | (out_ready & ~out_valid);

  rv32_sat_counter #(
    .W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bubble_inc),
    .clr   (bubble_clr),
    .cnt   (bubble_cnt)
  );

endmodule

// File: tb/tb_rv32_pipe_skid_queue.sv
// Self-checking bench for rv32_pipe_skid_queue: three instances (DEPTH=2,
// DEPTH=1, DEPTH=3 with a 4-bit bubble counter), a directed vector table,
// hand-written corner sequences, and randomized traffic checked against a
// queue-based reference model.
module tb_rv32_pipe_skid_queue;
  import rv32_pipe_pkg::*;

  localparam logic [31:0] NOP13 = 32'h13;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Per-instance stimulus (index 0: DEPTH=2, 1: DEPTH=1, 2: DEPTH=3/CNT_W=4).
  logic [2:0]  flush_v, hold_v, iv_v, or_v, clr_v;
  logic [31:0] id_v [3];

  logic        ir0, ov0, ir1, ov1, ir2, ov2;
  logic [31:0] od0, od1, od2;
  logic [1:0]  cnt0;
  logic [0:0]  cnt1;
  logic [1:0]  cnt2;
  logic [15:0] bc0, bc1;
  logic [3:0]  bc2;

  rv32_pipe_skid_queue #(.DATA_W(32), .DEPTH(2), .NOP_VAL(NOP13), .CNT_W(16)) u_d2 (
    .clk(clk), .rst_n(rst_n), .flush(flush_v[0]), .hold(hold_v[0]),
    .in_valid(iv_v[0]), .in_ready(ir0), .in_data(id_v[0]),
    .out_valid(ov0), .out_ready(or_v[0]), .out_data(od0),
    .count(cnt0), .bubble_cnt(bc0), .bubble_clr(clr_v[0]));

  rv32_pipe_skid_queue #(.DATA_W(32), .DEPTH(1), .NOP_VAL(NOP13), .CNT_W(16)) u_d1 (
    .clk(clk), .rst_n(rst_n), .flush(flush_v[1]), .hold(hold_v[1]),
    .in_valid(iv_v[1]), .in_ready(ir1), .in_data(id_v[1]),
    .out_valid(ov1), .out_ready(or_v[1]), .out_data(od1),
    .count(cnt1), .bubble_cnt(bc1), .bubble_clr(clr_v[1]));

  rv32_pipe_skid_queue #(.DATA_W(32), .DEPTH(3), .NOP_VAL(RV32_NOP), .CNT_W(4)) u_d3 (
    .clk(clk), .rst_n(rst_n), .flush(flush_v[2]), .hold(hold_v[2]),
    .in_valid(iv_v[2]), .in_ready(ir2), .in_data(id_v[2]),
    .out_valid(ov2), .out_ready(or_v[2]), .out_data(od2),
    .count(cnt2), .bubble_cnt(bc2), .bubble_clr(clr_v[2]));

  // Instance accessors.
  function automatic int depth_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 3;
  endfunction
  function automatic int bmax_of(input int i);
    return (i == 2) ? 15 : 65535;
  endfunction
  function automatic logic get_ov(input int i);
    return (i == 0) ? ov0 : (i == 1) ? ov1 : ov2;
  endfunction
  function automatic logic get_ir(input int i);
    return (i == 0) ? ir0 : (i == 1) ? ir1 : ir2;
  endfunction
  function automatic logic [31:0] get_od(input int i);
    return (i == 0) ? od0 : (i == 1) ? od1 : od2;
  endfunction
  function automatic int get_cnt(input int i);
    return (i == 0) ? int'(cnt0) : (i == 1) ? int'(cnt1) : int'(cnt2);
  endfunction
  function automatic int get_bc(input int i);
    return (i == 0) ? int'(bc0) : (i == 1) ? int'(bc1) : int'(bc2);
  endfunction

  // Reference model: contents as a plain FIFO queue, bubble count as an int.
  logic [31:0] mq [$];
  int          mbub;
  logic        p_valid, p_ready, accepted;
  logic [31:0] p_data;
  logic        stall_prev;
  logic [31:0] stall_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic set_in(input int i, input logic iv, input logic [31:0] d, input logic ordy,
                        input logic hd, input logic fl, input logic cl);
    iv_v[i] = iv; id_v[i] = d; or_v[i] = ordy; hold_v[i] = hd; flush_v[i] = fl; clr_v[i] = cl;
  endtask

  // Wait to mid-cycle, predict outputs from the model, compare.
  task automatic sample(input int i);
    @(negedge clk);
    if (stall_prev && iv_v[i])
      assert (id_v[i] == stall_data) else $error("upstream changed in_data while stalled");
    p_valid = !hold_v[i] && (mq.size() != 0);
    p_data  = p_valid ? mq[0] : NOP13;
    if (depth_of(i) >= 2) p_ready = !hold_v[i] && (mq.size() < depth_of(i));
    else                  p_ready = !hold_v[i] && ((mq.size() == 0) || or_v[i]);
    check($sformatf("u%0d out_valid", i),  32'(get_ov(i)),  32'(p_valid));
    check($sformatf("u%0d out_data", i),   get_od(i),       p_data);
    check($sformatf("u%0d in_ready", i),   32'(get_ir(i)),  32'(p_ready));
    check($sformatf("u%0d count", i),      32'(get_cnt(i)), 32'(mq.size()));
    check($sformatf("u%0d bubble_cnt", i), 32'(get_bc(i)),  32'(mbub));
  endtask

  // Apply this cycle's transfers to the model and move past the clock edge.
  task automatic advance(input int i);
    logic        push, pop;
    logic [31:0] tmp;
    push = iv_v[i] && p_ready && !flush_v[i];
    pop  = p_valid && or_v[i] && !flush_v[i];
    accepted   = push;
    stall_prev = iv_v[i] && !p_ready && !flush_v[i];
    stall_data = id_v[i];
    if (clr_v[i]) mbub = 0;
    else if ((flush_v[i] || (or_v[i] && !p_valid)) && (mbub < bmax_of(i))) mbub++;
    if (flush_v[i]) mq.delete();
    else begin
      if (pop)  tmp = mq.pop_front();
      if (push) mq.push_back(id_v[i]);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush_v = '0; hold_v = '0; iv_v = '0; or_v = '0; clr_v = '0;
    for (int k = 0; k < 3; k++) id_v[k] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mq.delete();
    mbub = 0;
    stall_prev = 1'b0;
  endtask

  task automatic rand_run(input int i, input int n);
    logic        pend, ivv, fl, hd, cl, ordy;
    logic [31:0] dd, pend_d;
    pend = 1'b0;
    pend_d = '0;
    for (int k = 0; k < n; k++) begin
      fl   = ($urandom_range(15) == 0);
      hd   = ($urandom_range(7) == 0);
      cl   = ($urandom_range(31) == 0);
      ordy = ($urandom_range(99) < 60);
      if (pend) begin ivv = 1'b1; dd = pend_d; end
      else begin ivv = ($urandom_range(99) < 70); dd = $urandom; end
      set_in(i, ivv, dd, ordy, hd, fl, cl);
      sample(i);
      advance(i);
      pend   = ivv && !accepted && !fl;
      pend_d = dd;
    end
  endtask

  // Directed vectors for the DEPTH=2 instance: inputs and expected outputs
  // for the same cycle.
  typedef struct {
    logic        iv;
    logic [31:0] din;
    logic        ordy;
    logic        hold;
    logic        flush;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_ready;
    int          e_count;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [31:0] din, input logic ordy,
                              input logic hd, input logic fl, input logic ev,
                              input logic [31:0] ed, input logic er, input int ec);
    vec_t v;
    v.iv = iv; v.din = din; v.ordy = ordy; v.hold = hd; v.flush = fl;
    v.e_valid = ev; v.e_data = ed; v.e_ready = er; v.e_count = ec;
    return v;
  endfunction

  vec_t tbl [24];

  initial begin
    //             iv  din    ordy hold flush | valid data   ready count
    tbl[0]  = mk(0, 32'h0, 0, 0, 0,  0, NOP13, 1, 0);  // reset state
    tbl[1]  = mk(1, 32'hA, 0, 0, 0,  0, NOP13, 1, 0);  // push A
    tbl[2]  = mk(1, 32'hB, 0, 0, 0,  1, 32'hA, 1, 1);  // push B
    tbl[3]  = mk(1, 32'hC, 0, 0, 0,  1, 32'hA, 0, 2);  // full, C stalled
    tbl[4]  = mk(1, 32'hC, 1, 0, 0,  1, 32'hA, 0, 2);  // pop A
    tbl[5]  = mk(1, 32'hC, 1, 0, 0,  1, 32'hB, 1, 1);  // pop B, push C
    tbl[6]  = mk(0, 32'h0, 1, 0, 0,  1, 32'hC, 1, 1);  // pop C
    tbl[7]  = mk(0, 32'h0, 0, 0, 0,  0, NOP13, 1, 0);  // empty again
    tbl[8]  = mk(1, 32'hA, 0, 0, 0,  0, NOP13, 1, 0);
    tbl[9]  = mk(1, 32'hB, 0, 0, 0,  1, 32'hA, 1, 1);
    tbl[10] = mk(1, 32'hE, 0, 1, 0,  0, NOP13, 0, 2);  // hold x3
    tbl[11] = mk(1, 32'hE, 0, 1, 0,  0, NOP13, 0, 2);
    tbl[12] = mk(1, 32'hE, 0, 1, 0,  0, NOP13, 0, 2);
    tbl[13] = mk(0, 32'h0, 0, 0, 0,  1, 32'hA, 0, 2);  // release: A again
    tbl[14] = mk(1, 32'hD, 0, 0, 1,  1, 32'hA, 0, 2);  // flush with D offered
    tbl[15] = mk(0, 32'h0, 0, 0, 0,  0, NOP13, 1, 0);
    tbl[16] = mk(0, 32'h0, 1, 0, 0,  0, NOP13, 1, 0);  // D never appears
    tbl[17] = mk(1, 32'h9, 0, 0, 0,  0, NOP13, 1, 0);
    tbl[18] = mk(1, 32'hD, 0, 0, 1,  1, 32'h9, 1, 1);  // flush while ready=1
    tbl[19] = mk(0, 32'h0, 0, 0, 0,  0, NOP13, 1, 0);
    tbl[20] = mk(1, 32'h7, 0, 0, 0,  0, NOP13, 1, 0);
    tbl[21] = mk(1, 32'h8, 0, 0, 0,  1, 32'h7, 1, 1);
    tbl[22] = mk(0, 32'h0, 0, 1, 1,  0, NOP13, 0, 2);  // flush + hold
    tbl[23] = mk(0, 32'h0, 0, 0, 0,  0, NOP13, 1, 0);  // flush won

    // DEPTH=2: directed table, then random traffic.
    do_reset();
    for (int r = 0; r < 24; r++) begin
      set_in(0, tbl[r].iv, tbl[r].din, tbl[r].ordy, tbl[r].hold, tbl[r].flush, 1'b0);
      sample(0);
      check($sformatf("vec%0d out_valid", r), 32'(ov0),  32'(tbl[r].e_valid));
      check($sformatf("vec%0d out_data", r),  od0,       tbl[r].e_data);
      check($sformatf("vec%0d in_ready", r),  32'(ir0),  32'(tbl[r].e_ready));
      check($sformatf("vec%0d count", r),     32'(cnt0), 32'(tbl[r].e_count));
      advance(0);
    end
    rand_run(0, 400);

    // DEPTH=1: streaming 1..8 at one per cycle with one cycle of latency.
    do_reset();
    for (int k = 0; k <= 8; k++) begin
      set_in(1, (k < 8), 32'(k + 1), 1'b1, 1'b0, 1'b0, 1'b0);
      sample(1);
      check($sformatf("stream%0d out_valid", k), 32'(ov1), (k > 0) ? 32'd1 : 32'd0);
      check($sformatf("stream%0d out_data", k),  od1,      (k > 0) ? 32'(k) : NOP13);
      if (k < 8) check($sformatf("stream%0d in_ready", k), 32'(ir1), 32'd1);
      advance(1);
    end
    rand_run(1, 400);

    // DEPTH=3, 4-bit bubble counter: saturation and clear priority.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      set_in(2, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      sample(2);
      if (k == 5 || k == 15 || k == 19)
        check($sformatf("bubble sat k=%0d", k), 32'(bc2), (k < 15) ? 32'(k) : 32'hF);
      advance(2);
    end
    set_in(2, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    sample(2);
    check("bubble before clr", 32'(bc2), 32'hF);
    advance(2);
    set_in(2, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    sample(2);
    check("bubble clr wins", 32'(bc2), 32'h0);
    advance(2);
    set_in(2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    sample(2);
    check("bubble after clr", 32'(bc2), 32'h1);
    advance(2);
    rand_run(2, 400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
